// File: rtl/seg7_pkg.sv
// ------------------------------------------------------------------
// seg7_pkg: glyph table and segment constants for 7-segment drivers
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value 0..F.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ------------------------------------------------------------------
// seg7_hex_decode: 4-bit hex nibble to active-low 7-segment glyph
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seg7_hex_decode (
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  import seg7_pkg::*;

  assign glyph_o = GLYPH_TABLE[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ------------------------------------------------------------------
// seg7_scan_driver: time-multiplexed common-anode 7-segment scanner
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [4*NUM_DIGITS-1:0]   data_in_i,
  input  logic [NUM_DIGITS-1:0]     dp_in_i,
  input  logic [NUM_DIGITS-1:0]     digit_en_i,
  output logic [7:0]                segments_o,
  output logic [NUM_DIGITS-1:0]     an_o
);

  import seg7_pkg::*;

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $fatal(1, "seg7_scan_driver: NUM_DIGITS must be in 1..16");
  end

  if (REFRESH_DIV < BLANK_CYCLES + 1) begin : g_bad_refresh_div
    $fatal(1, "seg7_scan_driver: REFRESH_DIV must be at least BLANK_CYCLES+1");
  end

  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0]              cur_nibble;
  logic [6:0]              cur_glyph;
  logic                    slot_wrap;
  logic                    slot_active;
  logic [NUM_DIGITS-1:0]   an_sel;

  assign cur_nibble = data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .glyph_o  (cur_glyph)
  );

  always_comb begin
    slot_wrap = (cnt_q == CNT_LAST);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Outputs reflect the slot state of this cycle, so they lag cnt/idx by one edge.
  always_comb begin
    slot_active    = (cnt_q >= BLANK_END) && en_q[idx_q];
    an_sel         = '0;
    an_sel[idx_q]  = 1'b1;
    an_d           = '1;
    seg_d          = SEG_BLANK;
    if (slot_active) begin
      an_d           = ~an_sel;
      seg_d[6:0]     = cur_glyph;
      seg_d[SEG_DP]  = ~dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dp_q   <= '0;
      en_q   <= '0;
    end else if (load_i) begin
      data_q <= data_in_i;
      dp_q   <= dp_in_i;
      en_q   <= digit_en_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign segments_o = seg_q;
  assign an_o       = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ------------------------------------------------------------------
// tb_seg7_scan_driver: scoreboard bench for the 7-segment scan driver
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_driver;

  localparam int ND = 4;

  // Hand-written glyphs from the display datasheet, active-low {g..a}.
  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk;
  logic          rst_n;
  logic          load_i;
  logic [15:0]   data_in_i;
  logic [3:0]    dp_in_i;
  logic [3:0]    digit_en_i;
  logic [7:0]    segments_o;
  logic [3:0]    an_o;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_i),
    .data_in_i  (data_in_i),
    .dp_in_i    (dp_in_i),
    .digit_en_i (digit_en_i),
    .segments_o (segments_o),
    .an_o       (an_o)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    string      nm;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [15:0] sh_data;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_en;
  string       phase_nm;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since the last reset release; output after edge k is tagged k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int slot_digit(int k);
    if (((k - 1) % 4) < 1) return -1;
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic logic [11:0] exp_out(int k, logic [15:0] d, logic [3:0] dp, logic [3:0] en);
    int         dg;
    logic [3:0] an;
    logic [3:0] nib;
    dg = slot_digit(k);
    if (dg < 0) return {4'hF, 8'hFF};
    if (!en[dg]) return {4'hF, 8'hFF};
    an      = 4'hF;
    an[dg]  = 1'b0;
    nib     = d[4*dg +: 4];
    return {an, ~dp[dg], GLY[nib]};
  endfunction

  task automatic push_exp(int k);
    exp_t       e;
    logic [11:0] v;
    v     = exp_out(k, sh_data, sh_dp, sh_en);
    e.cyc = k;
    e.an  = v[11:8];
    e.seg = v[7:0];
    e.nm  = phase_nm;
    sb.push_back(e);
  endtask

  // Caller sits at a negedge: drive for the next edge, expect its effect one edge later.
  task automatic cycle(logic ld, logic [15:0] d, logic [3:0] dp, logic [3:0] en);
    load_i     = ld;
    data_in_i  = d;
    dp_in_i    = dp;
    digit_en_i = en;
    if (ld) begin
      sh_data = d;
      sh_dp   = dp;
      sh_en   = en;
    end
    push_exp(cyc + 2);
    @(negedge clk);
  endtask

  task automatic check_now(string nm, logic [3:0] an_req, logic [7:0] seg_req);
    checks++;
    if (an_o !== an_req || segments_o !== seg_req) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h, expected an=%h seg=%h",
               nm, an_o, segments_o, an_req, seg_req);
    end
  endtask

  task automatic release_rst(logic ld, logic [15:0] d, logic [3:0] dp, logic [3:0] en);
    sh_data = '0;
    sh_dp   = '0;
    sh_en   = '0;
    rst_n   = 1'b1;
    push_exp(1);
    cycle(ld, d, dp, en);
  endtask

  task automatic mid_slot_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_immediate", 4'hF, 8'hFF);
    sb.delete();
    load_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_now("reset_held", 4'hF, 8'hFF);
  endtask

  // Scoreboard monitor: compares every tagged output, plus the one-hot anode invariant.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if ($countones(~an_o) > 1) begin
          errors++;
          $display("FAIL anode_onehot cyc=%0d: got an=%h, expected at most one low bit", cyc, an_o);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          checks++;
          if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s missed cyc=%0d: got now=%0d, expected at %0d", e.nm, e.cyc, cyc, e.cyc);
          end else if (an_o !== e.an || segments_o !== e.seg) begin
            errors++;
            $display("FAIL %s cyc=%0d: got an=%h seg=%h, expected an=%h seg=%h",
                     e.nm, cyc, an_o, segments_o, e.an, e.seg);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int v;
    int dg;
    rst_n      = 1'b0;
    load_i     = 1'b0;
    data_in_i  = '0;
    dp_in_i    = '0;
    digit_en_i = '0;
    sh_data    = '0;
    sh_dp      = '0;
    sh_en      = '0;
    phase_nm   = "reset";
    @(negedge clk);
    @(negedge clk);
    check_now("reset_state", 4'hF, 8'hFF);

    // Scan order: digits E,D,B,7 with glyphs 0,1,2,3.
    phase_nm = "scan_order";
    release_rst(1'b1, 16'h3210, 4'h0, 4'hF);
    repeat (34) cycle(1'b0, 16'h0000, 4'h0, 4'h0);

    // Reset in the middle of an active slot, then restart from idx 0.
    phase_nm = "after_reset";
    mid_slot_reset();
    release_rst(1'b1, 16'h3210, 4'h0, 4'hF);
    repeat (6) cycle(1'b0, 16'h0000, 4'h0, 4'h0);

    // All glyphs on digit 0 with decimal point lit, a new value per active cycle.
    phase_nm = "glyph_sweep";
    v = 0;
    for (int g = 0; g < 200 && v < 16; g++) begin
      dg = slot_digit(cyc + 2);
      cycle(1'b1, {12'h000, 4'(v)}, 4'b0001, 4'b0001);
      if (dg == 0) v++;
    end

    // Enable mask: digits 1 and 3 stay dark.
    phase_nm = "enable_mask";
    cycle(1'b1, 16'h4321, 4'b0100, 4'b0101);
    repeat (34) cycle(1'b0, 16'hAAAA, 4'hF, 4'hF);

    // Load exactly on the slot wrap edge.
    phase_nm = "wrap_load";
    cycle(1'b1, 16'h3210, 4'h0, 4'hF);
    while (((cyc + 1) % 4) != 0) cycle(1'b0, 16'h0000, 4'h0, 4'h0);
    cycle(1'b1, 16'hFFFF, 4'h0, 4'hF);
    repeat (20) cycle(1'b0, 16'h1234, 4'hF, 4'h0);

    // Long random run with sporadic loads.
    phase_nm = "random";
    for (int i = 0; i < 1000; i++) begin
      cycle(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
    end

    load_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
